// File: rtl/demux4x1_buf.sv
// rtl/demux4x1_buf.sv - 1-to-4 stream demux with a small FIFO per output channel
module demux4x1_buf #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [1:0]            in_sel,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic [3:0]            out_valid,
  input  logic [3:0]            out_ready,
  output logic [DATA_WIDTH-1:0] out_data_0,
  output logic [DATA_WIDTH-1:0] out_data_1,
  output logic [DATA_WIDTH-1:0] out_data_2,
  output logic [DATA_WIDTH-1:0] out_data_3,
  output logic [2:0]            count_0,
  output logic [2:0]            count_1,
  output logic [2:0]            count_2,
  output logic [2:0]            count_3
);

  localparam int         PTR_W = $clog2(DEPTH);
  localparam logic [2:0] FULL  = 3'(DEPTH);

  logic [DATA_WIDTH-1:0] r_mem [4][DEPTH];
  logic [PTR_W-1:0]      r_wptr [4];
  logic [PTR_W-1:0]      r_rptr [4];
  logic [2:0]            r_count [4];

  logic [3:0] w_full;
  logic [3:0] w_pop;
  logic [3:0] w_push_ch;
  logic       w_push;

  always_comb begin
    for (int c = 0; c < 4; c++) begin
      w_full[c]    = (r_count[c] == FULL);
      out_valid[c] = (r_count[c] != 3'd0);
      w_pop[c]     = out_valid[c] & out_ready[c];
    end
  end

  // A full channel still accepts a word when its head leaves in the same cycle.
  assign in_ready = ~w_full[in_sel] | w_pop[in_sel];
  assign w_push   = in_valid & in_ready;

  always_comb begin
    for (int c = 0; c < 4; c++) begin
      w_push_ch[c] = w_push & (in_sel == 2'(c));
    end
  end

  always_ff @(posedge clk) begin
    for (int c = 0; c < 4; c++) begin
      if (rst) begin
        r_wptr[c]  <= '0;
        r_rptr[c]  <= '0;
        r_count[c] <= 3'd0;
      end else begin
        if (w_push_ch[c]) begin
          r_mem[c][r_wptr[c]] <= in_data;
          r_wptr[c]           <= r_wptr[c] + PTR_W'(1);
        end
        if (w_pop[c]) begin
          r_rptr[c] <= r_rptr[c] + PTR_W'(1);
        end
        case ({w_push_ch[c], w_pop[c]})
          2'b10:   r_count[c] <= r_count[c] + 3'd1;
          2'b01:   r_count[c] <= r_count[c] - 3'd1;
          default: r_count[c] <= r_count[c];
        endcase
      end
    end
  end

  assign out_data_0 = r_mem[0][r_rptr[0]];
  assign out_data_1 = r_mem[1][r_rptr[1]];
  assign out_data_2 = r_mem[2][r_rptr[2]];
  assign out_data_3 = r_mem[3][r_rptr[3]];

  assign count_0 = r_count[0];
  assign count_1 = r_count[1];
  assign count_2 = r_count[2];
  assign count_3 = r_count[3];

endmodule
